// File: rtl/mem_write_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_seq_pkg
// Description : Shared widths and state encoding for the memory write
//               sequencer and its input FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_write_seq_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_ADDR_W  = 32;
    localparam int c_COUNT_W = 16;
    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_write_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word-fall-through read data and
//               a registered occupancy count. Pushes when full and pops when
//               empty are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_seq
// Description : Buffers a word stream in a FIFO and replays a requested
//               number of words to an Avalon write master, one command per
//               word at consecutive strided addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_seq
    import mem_write_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [c_ADDR_W-1:0]  base_addr,
    input  logic [c_COUNT_W-1:0] word_count,
    input  logic [c_DATA_W-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [c_DATA_W-1:0]  m_data,
    output logic [c_ADDR_W-1:0]  m_addr,
    output logic                 m_go,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic [c_COUNT_W-1:0] words_written
);

    localparam int                   c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]   c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_ADDR_W-1:0]  c_STRIDE    = c_ADDR_W'(ADDR_STRIDE);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_ADDR_W-1:0]   r_cur_addr;
    logic [c_COUNT_W-1:0]  r_word_count;
    logic [c_COUNT_W-1:0]  r_words_written;
    logic [c_COUNT_W-1:0]  w_words_inc;
    logic [c_DATA_W-1:0]   r_m_data;
    logic [c_ADDR_W-1:0]   r_m_addr;
    logic                  r_m_go;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_DATA_W-1:0]   w_fifo_data;
    logic [c_CNT_W-1:0]    w_fifo_count;

    // in_ready follows the registered occupancy and is held low during reset.
    assign in_ready      = resetn && (w_fifo_count != c_FIFO_FULL);
    assign w_push        = in_valid && resetn && !w_fifo_full;
    assign w_words_inc   = r_words_written + 1'b1;
    assign m_data        = r_m_data;
    assign m_addr        = r_m_addr;
    assign m_go          = r_m_go;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign words_written = r_words_written;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (w_push),
        .wr_data (in_data),
        .pop     (w_pop),
        .rd_data (w_fifo_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and FIFO pop; a word leaves the FIFO only when the master can take it.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (word_count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!w_fifo_empty && m_ready) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            // m_ready may still reflect the previous command here, so it is not consulted.
            ST_ISSUE: w_next_state = ST_ACK;
            ST_ACK: begin
                if (m_ready) begin
                    w_next_state = (w_words_inc == r_word_count) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Transfer bookkeeping and the registered command presented to the master.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cur_addr      <= '0;
            r_word_count    <= '0;
            r_words_written <= '0;
            r_m_data        <= '0;
            r_m_addr        <= '0;
            r_m_go          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur_addr      <= base_addr;
                        r_word_count    <= word_count;
                        r_words_written <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_pop) begin
                        r_m_data <= w_fifo_data;
                        r_m_addr <= r_cur_addr;
                        r_m_go   <= 1'b1;
                    end
                end
                ST_ISSUE: r_m_go <= 1'b0;
                ST_ACK: begin
                    if (m_ready) begin
                        r_words_written <= w_words_inc;
                        r_cur_addr      <= r_cur_addr + c_STRIDE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_write_seq
// Description : Self-checking bench for mem_write_seq: table-driven and
//               random transfers against a queue-based reference, plus
//               hand-written reset, backpressure and busy-start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_seq;

    localparam int DEPTH  = 8;
    localparam int STRIDE = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] m_data;
    logic [31:0] m_addr;
    logic        m_go;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [15:0] words_written;

    mem_write_seq #(.FIFO_DEPTH(DEPTH), .ADDR_STRIDE(STRIDE)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .m_data(m_data), .m_addr(m_addr), .m_go(m_go),
        .m_ready(m_ready), .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Words waiting to be offered, words accepted by the FIFO (reference), observed writes.
    logic [31:0] send_q[$];
    logic [31:0] model_q[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int go_cnt = 0, done_cnt = 0, go_long = 0, waits_cfg = 0, wait_cnt = 0;
    logic prev_go = 1'b0;

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          waits;
        int          npush;
        logic [31:0] exp_last;
        logic [15:0] exp_ww;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Stream producer, master model and write monitor, all acting on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                model_q.delete();
                m_ready  = 1'b1;
                wait_cnt = 0;
                in_valid = 1'b0;
                prev_go  = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (m_go) begin
                    go_cnt++;
                    if (prev_go) go_long++;
                    got_addr.push_back(m_addr);
                    got_data.push_back(m_data);
                    if (waits_cfg > 0) begin
                        m_ready  = 1'b0;
                        wait_cnt = waits_cfg;
                    end
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) m_ready = 1'b1;
                end
                prev_go = m_go;
                if (send_q.size() > 0) begin
                    in_valid = 1'b1;
                    in_data  = send_q[0];
                    if (in_ready) model_q.push_back(send_q.pop_front());
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
    end

    task automatic do_xfer(input string tag, input logic [31:0] base, input int cnt,
                           input int waits, input int spurious,
                           input logic [31:0] exp_last, input logic [15:0] exp_ww);
        int cyc;
        logic [31:0] ea;
        logic [31:0] ed;
        got_addr.delete();
        got_data.delete();
        go_cnt    = 0;
        done_cnt  = 0;
        go_long   = 0;
        waits_cfg = waits;
        base_addr = base;
        word_count = 16'(cnt);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (cnt == 0) chk({tag, "_done_latency"}, 32'(done), 32'd1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 500) begin
            if (spurious > 0 && cyc == spurious) begin
                start      = 1'b1;
                base_addr  = 32'h9000_0000;
                word_count = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_go_pulses"}, 32'(go_cnt), 32'(cnt));
        chk({tag, "_go_long"}, 32'(go_long), 32'd0);
        chk({tag, "_words_written"}, 32'(words_written), 32'(exp_ww));
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (cnt > 0 && got_addr.size() >= cnt)
            chk({tag, "_last_addr"}, got_addr[cnt-1], exp_last);
        for (int i = 0; i < cnt && i < got_addr.size(); i++) begin
            ea = base + 32'(i * STRIDE);
            ed = (i < model_q.size()) ? model_q[i] : 32'hDEAD_BEEF;
            chk($sformatf("%s_addr%0d", tag, i), got_addr[i], ea);
            chk($sformatf("%s_data%0d", tag, i), got_data[i], ed);
        end
        for (int i = 0; i < cnt; i++) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        int extra;
        logic [31:0] base;

        vecs[0] = '{32'h0000_1000, 3, 2, 3, 32'h0000_1008, 16'd3};
        vecs[1] = '{32'hFFFF_FFF8, 3, 0, 3, 32'h0000_0000, 16'd3};
        vecs[2] = '{32'h0000_0020, 5, 1, 7, 32'h0000_0030, 16'd5};
        vecs[3] = '{32'h0000_0100, 2, 3, 0, 32'h0000_0104, 16'd2};

        resetn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_data = '0; in_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_m_go", 32'(m_go), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        resetn = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Table-driven transfers: nominal, address wrap, surplus buffering, surplus reuse.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < vecs[v].npush; k++) begin
                if (v == 0) send_q.push_back(32'hA + 32'(k));
                else        send_q.push_back($urandom);
            end
            do_xfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].cnt, vecs[v].waits, 0,
                    vecs[v].exp_last, vecs[v].exp_ww);
        end

        // Zero-length transfer: done without any command.
        do_xfer("zero", 32'h0000_7000, 0, 0, 0, 32'h0, 16'd0);

        // Randomized transfers against the queue reference.
        for (int r = 0; r < 8; r++) begin
            cnt   = $urandom_range(1, 5);
            extra = $urandom_range(0, 1);
            base  = $urandom & 32'hFFFF_FFFC;
            for (int k = 0; k < cnt + extra; k++) send_q.push_back($urandom);
            do_xfer($sformatf("rnd%0d", r), base, cnt, $urandom_range(0, 3), 0,
                    base + 32'((cnt - 1) * STRIDE), 16'(cnt));
        end

        // Reset while the second of four words is awaiting acknowledgement.
        for (int k = 0; k < 4; k++) send_q.push_back($urandom);
        repeat (10) @(posedge clk);
        #1;
        go_cnt = 0; go_long = 0; waits_cfg = 3;
        base_addr = 32'h0000_5000; word_count = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(go_cnt == 2 && !m_go && busy) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrst_reached_ack", 32'(cyc < 200), 32'd1);
        resetn = 1'b0;
        send_q.delete();
        @(posedge clk); #1;
        chk("midrst_m_go", 32'(m_go), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_m_addr", m_addr, 32'd0);
        chk("midrst_m_data", m_data, 32'd0);
        chk("midrst_ww", 32'(words_written), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        go_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_go", 32'(go_cnt), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        // Nine words into an eight-deep FIFO with no transfer running.
        for (int k = 0; k < 9; k++) send_q.push_back(32'hF000_0000 + 32'(k));
        repeat (12) @(posedge clk);
        #1;
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_level", 32'(model_q.size()), 32'd8);
        chk("fill_held", 32'(send_q.size()), 32'd1);
        do_xfer("fill_pop1", 32'h0000_0200, 1, 0, 0, 32'h0000_0200, 16'd1);
        chk("fill_ninth_in", 32'(model_q.size()), 32'd8);
        do_xfer("fill_drain", 32'h0000_0300, 8, 1, 0, 32'h0000_031C, 16'd8);
        chk("fill_ready_again", 32'(in_ready), 32'd1);

        // Start pulsed mid-transfer must not disturb the running one.
        for (int k = 0; k < 3; k++) send_q.push_back($urandom);
        do_xfer("busy_start", 32'h0000_4000, 3, 2, 4, 32'h0000_4008, 16'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
